psum_drain: RTL

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/psum_drain.sv
// psum_drain
// ----------
// Drains partial sums from the bottom row of a systolic array. The columns
// arrive diagonally skewed: column c reports its result c cycles after
// column 0. This block delays each column so that a whole result row lines
// up in a single cycle, then queues the aligned row in a small FIFO for a
// downstream consumer that has a valid/ready handshake.
//
// Parameters
//   N_COLS      number of array columns drained
//   DATA_WIDTH  width of one psum (signed, passed through untouched)
//   FIFO_DEPTH  number of queued rows (power of two, >= 2)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   col_psum_in   skewed psums, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   col_valid_in  skewed valids, bit c = column c
//   out_row       head row of the FIFO, all-zero while out_valid is low
//   out_valid     FIFO holds at least one row
//   out_ready     consumer takes the head row when out_valid is high
//   err_clr       clears the sticky error flags
//   skew_err      sticky: an aligned row had a mix of valid and invalid columns
//   ovf_err       sticky: a complete row was dropped because the FIFO was full
//   row_count     rows accepted into the FIFO since reset (wraps at 16 bits)

module psum_drain #(
   parameter int N_COLS     = 2,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_COLS*DATA_WIDTH-1:0] col_psum_in,
   input  logic [N_COLS-1:0]            col_valid_in,
   output logic [N_COLS*DATA_WIDTH-1:0] out_row,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         err_clr,
   output logic                         skew_err,
   output logic                         ovf_err,
   output logic [15:0]                  row_count
);

   localparam int ROW_W = N_COLS * DATA_WIDTH;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ROW_W-1:0]  aligned_row;
   logic [N_COLS-1:0] aligned_valid;

   // Deskew: column c is delayed by (N_COLS-1-c) stages so that every column
   // of a row reaches the aligned bus in the cycle the last column reports.
   // The last column needs no delay and is wired straight through.
   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      localparam int STAGES = N_COLS - 1 - c;

      if (STAGES == 0) begin : g_direct
         assign aligned_row[c*DATA_WIDTH +: DATA_WIDTH] = col_psum_in[c*DATA_WIDTH +: DATA_WIDTH];
         assign aligned_valid[c]                        = col_valid_in[c];
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] stage_data [STAGES];
         logic [STAGES-1:0]     stage_valid;

         // Data and valid travel together so a reset wipes any partly
         // captured row along with its payload.
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int s = 0; s < STAGES; s++) begin
                  stage_data[s] <= '0;
               end
               stage_valid <= '0;
            end else begin
               stage_data[0]  <= col_psum_in[c*DATA_WIDTH +: DATA_WIDTH];
               stage_valid[0] <= col_valid_in[c];
               for (int s = 1; s < STAGES; s++) begin
                  stage_data[s]  <= stage_data[s-1];
                  stage_valid[s] <= stage_valid[s-1];
               end
            end
         end

         assign aligned_row[c*DATA_WIDTH +: DATA_WIDTH] = stage_data[STAGES-1];
         assign aligned_valid[c]                        = stage_valid[STAGES-1];
      end
   end

   logic [ROW_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] occupancy;

   logic row_complete;
   logic row_mixed;
   logic fifo_full;
   logic push;
   logic pop;
   logic drop;

   // A full FIFO still accepts a row when the head leaves at the same edge,
   // so a consumer running at full rate never causes a drop.
   always_comb begin
      row_complete = &aligned_valid;
      row_mixed    = (|aligned_valid) && !row_complete;
      fifo_full    = (occupancy == CNT_W'(FIFO_DEPTH));
      out_valid    = (occupancy != '0);
      pop          = out_valid && out_ready;
      push         = row_complete && (!fifo_full || pop);
      drop         = row_complete && fifo_full && !pop;
   end

   // The head is only ever read from storage, never bypassed from the
   // aligned bus, and is masked to zero whenever nothing is queued.
   always_comb begin
      out_row = '0;
      if (out_valid) begin
         out_row = mem[rd_ptr];
      end
   end

   // Row storage needs no reset: the occupancy counter decides what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= aligned_row;
      end
   end

   // Pointers wrap explicitly at FIFO_DEPTH; the occupancy counter tells
   // full from empty when the pointers are equal.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         row_count <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            row_count <= row_count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            occupancy <= occupancy + CNT_W'(1);
         end else if (pop && !push) begin
            occupancy <= occupancy - CNT_W'(1);
         end
      end
   end

   // Sticky error flags: a new error at the same edge as err_clr wins, so an
   // event is never lost to a clear that raced it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         skew_err <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         if (row_mixed) begin
            skew_err <= 1'b1;
         end else if (err_clr) begin
            skew_err <= 1'b0;
         end
         if (drop) begin
            ovf_err <= 1'b1;
         end else if (err_clr) begin
            ovf_err <= 1'b0;
         end
      end
   end

endmodule
